// File: rtl/cla_pipe_adder.sv
// Pipelined carry look-ahead adder/subtractor built from 4-bit CLA groups.
// Optional macro CLA_SATURATE_EN clamps the sum on signed overflow.
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  logic             w_en;
  logic             w_v  [STAGES];
  logic [WIDTH-1:0] w_a  [STAGES];
  logic [WIDTH-1:0] w_b  [STAGES];
  logic [WIDTH-1:0] w_si [STAGES];
  logic [WIDTH-1:0] w_so [STAGES];
  logic             w_ci [STAGES];
  logic             w_co [STAGES];
  logic             w_cm [STAGES];
  logic [WIDTH-1:0] w_fin;
  logic             w_ovf;

  logic             r_v [STAGES];
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  // Returns {carry into bit 3, group carry-out, sum[3:0]}.
  function automatic logic [5:0] cla4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic       gg;
    logic       gp;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
    c[4] = gg | (gp & ci);
    return {c[3], c[4], p ^ c[3:0]};
  endfunction

  assign w_en     = !r_v[STAGES-1] || out_ready;
  assign in_ready = w_en;

  always_comb begin : p_stage_in
    w_v[0]  = in_valid;
    w_a[0]  = a;
    w_b[0]  = sub ? ~b : b;
    w_ci[0] = sub | cin;
    w_si[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_v[k]  = r_v[k-1];
      w_a[k]  = r_a[k-1];
      w_b[k]  = r_b[k-1];
      w_ci[k] = r_c[k-1];
      w_si[k] = r_s[k-1];
    end
  end

  always_comb begin : p_slice
    logic [5:0] w_g;
    logic       w_c;
    w_g = '0;
    w_c = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      w_so[k] = w_si[k];
      w_cm[k] = 1'b0;
      w_c     = w_ci[k];
      for (int g = 0; g < NG; g++) begin
        w_g = cla4(w_a[k][k*SW+g*4 +: 4],
                   w_b[k][k*SW+g*4 +: 4],
                   w_c);
        w_so[k][k*SW+g*4 +: 4] = w_g[3:0];
        w_c     = w_g[4];
        w_cm[k] = w_g[5];
      end
      w_co[k] = w_c;
    end
  end

  assign w_ovf = w_cm[STAGES-1] ^ w_co[STAGES-1];

`ifdef CLA_SATURATE_EN
  // Carry-out distinguishes negative (1) from positive (0) overflow.
  assign w_fin = w_ovf
    ? {w_co[STAGES-1], {(WIDTH-1){w_cm[STAGES-1]}}}
    : w_so[STAGES-1];
`else
  assign w_fin = w_so[STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= 1'b0;
      end
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= w_v[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        r_a[k] <= w_a[k];
        r_b[k] <= w_b[k];
        r_s[k] <= w_so[k];
        r_c[k] <= w_co[k];
      end
      if (w_v[STAGES-1]) begin
        r_sum  <= w_fin;
        r_cout <= w_co[STAGES-1];
        r_ovf  <= w_ovf;
        r_zero <= (w_fin == '0);
        r_neg  <= w_fin[WIDTH-1];
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=16, STAGES=2).
// Expected results come from integer arithmetic on the operands.
`timescale 1ns/1ps
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(16), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  function automatic exp_t model(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c,
    input logic        s
  );
    int   ua, ub, sa, sb, ci, ut, st;
    exp_t e;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    ci = c ? 1 : 0;
    if (s) begin
      ut     = ua - ub;
      st     = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      ut     = ua + ub + ci;
      st     = sa + sb + ci;
      e.cout = (ut > 65535);
    end
    e.sum = ut[15:0];
    e.ovf = (st > 32767) || (st < -32768);
`ifdef CLA_SATURATE_EN
    if (st > 32767) e.sum = 16'h7FFF;
    else if (st < -32768) e.sum = 16'h8000;
`endif
    e.zero = (e.sum == 16'h0000);
    e.neg  = e.sum[15];
    return e;
  endfunction

  function automatic logic [15:0] rv();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(
    input  logic        v,
    input  logic [15:0] xa,
    input  logic [15:0] xb,
    input  logic        xc,
    input  logic        xs,
    input  logic        ordy,
    output logic        acc
  );
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = xa;
    b         = xb;
    cin       = xc;
    sub       = xs;
    out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(xa, xb, xc, xs));
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      g = {sum, cout, ovf, zero, neg};
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got sum=%h c=%b v=%b z=%b n=%b, expected none",
                 sum, cout, ovf, zero, neg);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          n_bad++;
          $display("FAIL result: got sum=%h c=%b v=%b z=%b n=%b, expected sum=%h c=%b v=%b z=%b n=%b",
                   sum, cout, ovf, zero, neg,
                   e.sum, e.cout, e.ovf, e.zero, e.neg);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   cyc;
    int   accepted;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outputs", {sum, cout, ovf, zero, neg}, 0);

    // Directed operands with a latency check on the first one.
    step(1, 16'h0001, 16'hFFFF, 0, 0, 1, acc);
    chk("t1_accept", acc, 1);
    step(0, 0, 0, 0, 0, 1, acc);
    chk("t1_lat1_valid", out_valid, 0);
    step(0, 0, 0, 0, 0, 1, acc);
    chk("t1_lat2_valid", out_valid, 1);
    step(1, 16'h7FFF, 16'h0001, 0, 0, 1, acc);
    step(1, 16'h0005, 16'h0007, 1, 1, 1, acc);
    repeat (3) step(0, 0, 0, 0, 0, 1, acc);

    // Fill with the consumer stalled, then drain.
    step(1, 16'd1, 16'd1, 0, 0, 0, acc);
    chk("t4_op1_accept", acc, 1);
    step(1, 16'd2, 16'd2, 0, 0, 0, acc);
    chk("t4_op2_accept", acc, 1);
    step(1, 16'd3, 16'd3, 0, 0, 0, acc);
    chk("t4_full_in_ready", in_ready, 0);
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++)
      step(1, 16'd3, 16'd3, 0, 0, 1, acc);
    chk("t4_op3_accept", acc, 1);
    chk("t4_out1_valid", out_valid, 1);
    step(0, 0, 0, 0, 0, 1, acc);
    chk("t4_out2_valid", out_valid, 1);
    step(0, 0, 0, 0, 0, 1, acc);
    chk("t4_out3_valid", out_valid, 1);
    step(0, 0, 0, 0, 0, 1, acc);
    chk("t4_empty_valid", out_valid, 0);

    // Reset with two ops in flight.
    step(1, 16'h1111, 16'h2222, 0, 0, 0, acc);
    step(1, 16'h3333, 16'h4444, 0, 0, 0, acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_valid_after_rst", out_valid, 0);
    chk("t5_ready_after_rst", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, acc);
      chk("t5_no_ghost", out_valid, 0);
    end

    // Random traffic with random back-pressure.
    accepted = 0;
    cyc      = 0;
    while (accepted < 10000 && cyc < 60000) begin
      step($urandom_range(0, 9) < 7, rv(), rv(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7, acc);
      if (acc) accepted++;
      cyc++;
    end
    chk("rand_ops_accepted", accepted, 10000);

    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      step(0, 0, 0, 0, 0, 1, acc);
      cyc++;
    end
    chk("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
